// File: rtl/h_wr_addr_gen.sv
// h_wr_addr_gen: write-side address generator for the LSTM hidden-state memory.
// Lays out TIMESTEPS blocks of LAYER_SIZE words from BASE, one registered write per h word.
module h_wr_addr_gen #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int LAYER_SIZE = 53,
    parameter int TIMESTEPS  = 7,
    parameter int BASE       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_step_done,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int CW = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1;
    localparam int SW = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
    localparam logic [CW-1:0] CELL_LAST = CW'(LAYER_SIZE - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(TIMESTEPS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]         cell_q;
    logic [SW-1:0]         step_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic accept;
    logic cell_last;
    logic final_wr;

    // i_start always wins over a same-cycle i_valid
    assign accept    = (state_q == WRITE) && i_valid && !i_start;
    assign cell_last = (cell_q == CELL_LAST);
    assign final_wr  = accept && cell_last && (step_q == STEP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (i_start) state_d = WRITE;
            end
            WRITE: begin
                if (final_wr) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cell_q      <= '0;
            step_q      <= '0;
            addr_q      <= ADDR_BASE;
            o_we        <= 1'b0;
            o_addr      <= '0;
            o_data      <= '0;
            o_step_done <= 1'b0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_we        <= 1'b0;
            o_step_done <= 1'b0;
            o_busy      <= (state_d == WRITE);
            o_done      <= (state_d == DONE);
            if (i_start) begin
                cell_q <= '0;
                step_q <= '0;
                addr_q <= ADDR_BASE;
                o_err  <= 1'b0;
            end else if (accept) begin
                o_we   <= 1'b1;
                o_addr <= addr_q;
                o_data <= i_data;
                // hold on the final word so the counter stays inside the region
                if (!final_wr) addr_q <= addr_q + ADDR_WIDTH'(1);
                if (cell_last) begin
                    cell_q      <= '0;
                    o_step_done <= 1'b1;
                    if (step_q == STEP_LAST) step_q <= '0;
                    else step_q <= step_q + SW'(1);
                end else begin
                    cell_q <= cell_q + CW'(1);
                end
            end else if (i_valid && state_q != WRITE) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_h_wr_addr_gen.sv
// Scoreboard bench for h_wr_addr_gen: stimulus pushes expected writes,
// a negedge monitor pops and compares each presented write.
module tb_h_wr_addr_gen;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int LS = 53;
    localparam int TS = 7;
    localparam int NW = LS * TS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic          o_step_done;
    logic          o_done;
    logic          o_busy;
    logic          o_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          sd;
        logic          dn;
        logic          bz;
    } exp_t;

    exp_t exp_q[$];

    h_wr_addr_gen dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_we        (o_we),
        .o_addr      (o_addr),
        .o_data      (o_data),
        .o_step_done (o_step_done),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [DW-1:0] d);
        exp_t e;
        e.addr = AW'(idx);
        e.data = d;
        e.sd   = ((idx % LS) == LS - 1);
        e.dn   = (idx == NW - 1);
        e.bz   = (idx != NW - 1);
        exp_q.push_back(e);
    endtask

    // drive for one rising edge, return 1 time unit after it
    task automatic cyc(input logic s, input logic v, input logic [DW-1:0] d);
        i_start = s;
        i_valid = v;
        i_data  = d;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_we"},   {31'd0, o_we}, 0);
        chk({nm, "_addr"}, {20'd0, o_addr}, 0);
        chk({nm, "_data"}, {16'd0, o_data}, 0);
        chk({nm, "_flags"},
            {28'd0, o_step_done, o_done, o_busy, o_err}, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (o_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("addr", {20'd0, o_addr}, {20'd0, e.addr});
                    chk("data", {16'd0, o_data}, {16'd0, e.data});
                    chk("step_done", {31'd0, o_step_done}, {31'd0, e.sd});
                    chk("done", {31'd0, o_done}, {31'd0, e.dn});
                    chk("busy", {31'd0, o_busy}, {31'd0, e.bz});
                end
            end else begin
                chk("step_done_no_we", {31'd0, o_step_done}, 0);
            end
        end
    end

    initial begin
        // reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk_all_zero("idle");
        end

        // valid in IDLE -> error, no write
        cyc(0, 1, 16'h0005);
        chk("err_idle", {31'd0, o_err}, 1);
        cyc(0, 0, 0);
        chk("err_sticky", {31'd0, o_err}, 1);

        // full gap-free sequence
        cyc(1, 0, 0);
        chk("start_clr_err", {31'd0, o_err}, 0);
        chk("busy_after_start", {31'd0, o_busy}, 1);
        for (int i = 0; i < NW; i++) begin
            push(i, DW'(i));
            cyc(0, 1, DW'(i));
        end
        cyc(0, 0, 0);
        chk("done_hold", {31'd0, o_done}, 1);
        chk("busy_end", {31'd0, o_busy}, 0);
        chk("q_empty_full", exp_q.size(), 0);

        // gapped sequence, restarted from DONE
        cyc(1, 0, 0);
        chk("done_clr", {31'd0, o_done}, 0);
        for (int i = 0; i < NW; i++) begin
            push(i, DW'(i));
            cyc(0, 1, DW'(i));
            cyc(0, 0, 16'hFFFF);
        end
        chk("q_empty_gap", exp_q.size(), 0);
        chk("done_gap", {31'd0, o_done}, 1);

        // valid after done -> error, done stays
        cyc(0, 1, 16'h0007);
        chk("err_done", {31'd0, o_err}, 1);
        chk("done_keep", {31'd0, o_done}, 1);
        cyc(0, 0, 0);
        chk("err_sticky2", {31'd0, o_err}, 1);

        // restart mid-sequence with a same-cycle dropped word
        cyc(1, 0, 0);
        chk("err_clr2", {31'd0, o_err}, 0);
        for (int i = 0; i < 60; i++) begin
            push(i, DW'(16'h1000 + i));
            cyc(0, 1, DW'(16'h1000 + i));
        end
        cyc(1, 1, 16'hBEEF);
        chk("restart_no_we", {31'd0, o_we}, 0);
        chk("restart_err", {31'd0, o_err}, 0);
        chk("restart_busy", {31'd0, o_busy}, 1);
        for (int i = 0; i < NW; i++) begin
            push(i, DW'(16'h2000 + i));
            cyc(0, 1, DW'(16'h2000 + i));
        end
        cyc(0, 0, 0);
        chk("restart_done", {31'd0, o_done}, 1);
        chk("restart_err_end", {31'd0, o_err}, 0);
        chk("q_empty_restart", exp_q.size(), 0);

        // async reset mid-sequence
        cyc(1, 0, 0);
        for (int i = 0; i < 100; i++) begin
            push(i, DW'(i));
            cyc(0, 1, DW'(i));
        end
        i_valid = 1'b1;
        i_data  = 16'd100;
        #6;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        rst = 1'b1;
        cyc(0, 0, 0);
        chk_all_zero("post_rst");
        cyc(0, 1, 16'h0033);
        chk("post_rst_err", {31'd0, o_err}, 1);
        chk("post_rst_no_we", {31'd0, o_we}, 0);
        repeat (3) cyc(0, 0, 0);
        chk("q_empty_final", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
